// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: entry layout, pitch codes,
// pitch-to-divisor table builder and FSM state enum. The MELODY_GAP_EN macro is consumed by melody_seq.
package melody_pkg;

    localparam int PITCH_W = 4;
    localparam int BEATS_W = 4;
    localparam int ENTRY_W = PITCH_W + BEATS_W;
    localparam int DIV_W   = 22;
    localparam int DUR_W   = 28;
    localparam int IDX_W   = 4;
    localparam int SONG_W  = 16 * ENTRY_W;

    localparam logic [PITCH_W-1:0] PITCH_REST = 4'd0;
    localparam logic [PITCH_W-1:0] PITCH_C4   = 4'd1;
    localparam logic [PITCH_W-1:0] PITCH_D4   = 4'd3;
    localparam logic [PITCH_W-1:0] PITCH_E4   = 4'd5;
    localparam logic [PITCH_W-1:0] PITCH_F4   = 4'd6;
    localparam logic [PITCH_W-1:0] PITCH_G4   = 4'd8;
    localparam logic [PITCH_W-1:0] PITCH_A4   = 4'd10;
    localparam logic [PITCH_W-1:0] PITCH_B4   = 4'd12;
    localparam logic [PITCH_W-1:0] PITCH_C5   = 4'd13;
    localparam logic [PITCH_W-1:0] PITCH_D5   = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PLAY = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } melody_state_t;

    // Entry 0 sits in the least significant byte: a short nursery tune, end marker at entry 14.
    localparam logic [SONG_W-1:0] SONG_DEFAULT = {
        8'h00, 8'h00, 8'h12, 8'h31, 8'h31, 8'h51, 8'h51, 8'h61,
        8'h61, 8'h82, 8'hA1, 8'hA1, 8'h81, 8'h81, 8'h11, 8'h11
    };

    // Whole-hertz note frequencies; the divisor table is derived from these.
    function automatic int pitch_freq(input logic [PITCH_W-1:0] p);
        case (p)
            4'd1:    return 262;
            4'd2:    return 277;
            4'd3:    return 294;
            4'd4:    return 311;
            4'd5:    return 330;
            4'd6:    return 349;
            4'd7:    return 370;
            4'd8:    return 392;
            4'd9:    return 415;
            4'd10:   return 440;
            4'd11:   return 466;
            4'd12:   return 494;
            4'd13:   return 523;
            4'd14:   return 554;
            4'd15:   return 587;
            default: return 0;
        endcase
    endfunction

    function automatic logic [16*DIV_W-1:0] make_div_table(input int clk_hz);
        logic [16*DIV_W-1:0] t;
        t = '0;
        for (int p = 1; p < 16; p++) begin
            t[p*DIV_W +: DIV_W] = DIV_W'(clk_hz / (2 * pitch_freq(PITCH_W'(p))) - 1);
        end
        return t;
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational song table: one 8-bit {pitch, beats} entry per address.
module melody_rom
    import melody_pkg::*;
#(
    parameter int                SONG_LEN = 16,
    parameter logic [SONG_W-1:0] SONG     = SONG_DEFAULT
) (
    input  logic [IDX_W-1:0]   addr,
    output logic [ENTRY_W-1:0] data
);

    // Addresses past the table read as an end marker.
    always_comb begin
        data = '0;
        if (int'(addr) < SONG_LEN) begin
            data = SONG[int'(addr)*ENTRY_W +: ENTRY_W];
        end
    end

endmodule

// File: rtl/melody_seq.sv
// Melody sequencer: steps through the song table and drives a tone-generator divisor.
// Define MELODY_GAP_EN to insert a silent articulation gap after every note.
module melody_seq
    import melody_pkg::*;
#(
    parameter int                CLK_HZ      = 100_000_000,
    parameter int                BEAT_CYCLES = 12_500_000,
    parameter int                GAP_CYCLES  = 1_000_000,
    parameter int                SONG_LEN    = 16,
    parameter logic [SONG_W-1:0] SONG        = SONG_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               play,
    input  logic               stop,
    output logic [DIV_W-1:0]   note_div,
    output logic               mute,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   note_idx,
    output melody_state_t      fsm_state
);

    localparam logic [16*DIV_W-1:0] DIV_TABLE = make_div_table(CLK_HZ);
    localparam logic [DUR_W-1:0]    BEAT_LEN  = DUR_W'(BEAT_CYCLES);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(SONG_LEN - 1);

    if (SONG_LEN < 1 || SONG_LEN > 16 || BEAT_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_params
        $error("melody_seq: parameter out of range");
    end

    logic                play_q;
    logic                play_edge;
    logic [DUR_W-1:0]    dur_cnt;
    logic [ENTRY_W-1:0]  entry;
    logic [PITCH_W-1:0]  pitch;
    logic [BEATS_W-1:0]  beats;
`ifdef MELODY_GAP_EN
    localparam logic [DUR_W-1:0] GAP_LEN = DUR_W'(GAP_CYCLES);
    logic [DUR_W-1:0]    gap_cnt;
`endif

    melody_rom #(
        .SONG_LEN (SONG_LEN),
        .SONG     (SONG)
    ) u_rom (
        .addr (note_idx),
        .data (entry)
    );

    assign pitch     = entry[ENTRY_W-1 -: PITCH_W];
    assign beats     = entry[BEATS_W-1:0];
    assign play_edge = play & ~play_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_state <= S_IDLE;
            play_q    <= 1'b0;
            dur_cnt   <= '0;
            note_div  <= '0;
            mute      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            note_idx  <= '0;
`ifdef MELODY_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            play_q <= play;
            done   <= 1'b0;
            // Abort wins over everything, including a play edge arriving the same cycle.
            if (stop && fsm_state != S_IDLE) begin
                fsm_state <= S_IDLE;
                busy      <= 1'b0;
                mute      <= 1'b1;
                note_div  <= '0;
                dur_cnt   <= '0;
`ifdef MELODY_GAP_EN
                gap_cnt   <= '0;
`endif
            end else begin
                case (fsm_state)
                    S_IDLE: begin
                        if (play_edge && !stop) begin
                            fsm_state <= S_LOAD;
                            busy      <= 1'b1;
                            note_idx  <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (beats == '0) begin
                            fsm_state <= S_DONE;
                            done      <= 1'b1;
                            mute      <= 1'b1;
                            note_div  <= '0;
                        end else begin
                            note_div  <= DIV_TABLE[int'(pitch)*DIV_W +: DIV_W];
                            mute      <= (pitch == PITCH_REST);
                            dur_cnt   <= DUR_W'(beats) * BEAT_LEN - DUR_W'(1);
                            fsm_state <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (dur_cnt != '0) begin
                            dur_cnt <= dur_cnt - DUR_W'(1);
                        end else begin
`ifdef MELODY_GAP_EN
                            fsm_state <= S_GAP;
                            mute      <= 1'b1;
                            gap_cnt   <= GAP_LEN - DUR_W'(1);
`else
                            if (note_idx == LAST_IDX) begin
                                fsm_state <= S_DONE;
                                done      <= 1'b1;
                                mute      <= 1'b1;
                                note_div  <= '0;
                            end else begin
                                note_idx  <= note_idx + IDX_W'(1);
                                fsm_state <= S_LOAD;
                            end
`endif
                        end
                    end
`ifdef MELODY_GAP_EN
                    S_GAP: begin
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - DUR_W'(1);
                        end else if (note_idx == LAST_IDX) begin
                            fsm_state <= S_DONE;
                            done      <= 1'b1;
                            mute      <= 1'b1;
                            note_div  <= '0;
                        end else begin
                            note_idx  <= note_idx + IDX_W'(1);
                            fsm_state <= S_LOAD;
                        end
                    end
`endif
                    S_DONE: begin
                        fsm_state <= S_IDLE;
                        busy      <= 1'b0;
                    end
                    default: begin
                        fsm_state <= S_IDLE;
                        busy      <= 1'b0;
                        mute      <= 1'b1;
                        note_div  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
